// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter
// Shares one AXI4 read address/data channel pair between the instruction-fetch
// and data-load requesters. Grants go into a single-entry AR holding register
// tagged with a per-requester ID. Returning R beats are steered back by ID.
// Each requester may have one read outstanding, so both reads can overlap.
module axi_read_arbiter #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clock,
  input  logic        reset,

  // instruction-fetch requester
  input  logic        inst_request,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_address,
  output logic        inst_address_ready,
  output logic [31:0] inst_read_data,
  output logic        inst_data_ready,

  // data-load requester
  input  logic        data_request,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_address,
  output logic        data_address_ready,
  output logic [31:0] data_read_data,
  output logic        data_data_ready,

  // AXI read address channel
  output logic [3:0]  axi_read_address_id,
  output logic [31:0] axi_read_address,
  output logic [7:0]  axi_read_address_length,
  output logic [2:0]  axi_read_address_size,
  output logic [1:0]  axi_read_address_burst,
  output logic [1:0]  axi_read_address_lock,
  output logic [3:0]  axi_read_address_cache,
  output logic [2:0]  axi_read_address_protection,
  output logic        axi_read_address_valid,
  input  logic        axi_read_address_ready,

  // AXI read data channel
  input  logic [3:0]  axi_read_data_id,
  input  logic [31:0] axi_read_data,
  input  logic [1:0]  axi_read_data_response,
  input  logic        axi_read_data_last,
  input  logic        axi_read_data_valid,
  output logic        axi_read_data_ready,

  output logic        protocol_error
);

  localparam int NREQ     = 2;
  localparam int REQ_INST = 0;
  localparam int REQ_DATA = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_QUEUED = 2'd1,
    ST_WAIT_R = 2'd2
  } req_state_t;

  // requester-indexed views of the two ports
  logic [NREQ-1:0]       req_vec;
  logic [NREQ-1:0][3:0]  id_vec;
  logic [NREQ-1:0]       eligible;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       r_match;
  logic [NREQ-1:0]       data_ready_vec;
  logic [NREQ-1:0][31:0] read_data_vec;

  // AR holding register
  logic        ar_full_reg,  ar_full_next;
  logic        ar_owner_reg, ar_owner_next;
  logic [3:0]  ar_id_reg,    ar_id_next;
  logic [31:0] ar_addr_reg,  ar_addr_next;
  logic [1:0]  ar_size_reg,  ar_size_next;

  // index of the requester granted most recently (0 = instruction)
  logic        last_grant_reg, last_grant_next;

  logic        r_ready_reg;
  logic        protocol_error_reg;

  logic        ar_fire;
  logic        ar_free;
  logic        r_fire;

  assign req_vec = {data_request, inst_request};
  assign id_vec  = {DATA_ID, INST_ID};

  assign ar_fire = ar_full_reg & axi_read_address_ready;
  // The register can take a new grant in the same cycle its current entry leaves.
  assign ar_free = ~ar_full_reg | axi_read_address_ready;
  assign r_fire  = axi_read_data_valid & r_ready_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      localparam logic OWNER = (gi == REQ_DATA);

      req_state_t  state_reg, state_next;
      logic        data_ready_reg;
      logic [31:0] read_data_reg;

      assign eligible[gi] = req_vec[gi] & (state_reg == ST_IDLE);
      // A beat belongs to this requester only while it waits for one.
      assign r_match[gi]  = r_fire & (axi_read_data_id == id_vec[gi]) &
                            (state_reg == ST_WAIT_R);

      // Requester state register
      always_ff @(posedge clock) begin
        if (reset) begin
          state_reg <= ST_IDLE;
        end else begin
          state_reg <= state_next;
        end
      end

      // Requester next-state: IDLE -> QUEUED -> WAIT_R -> IDLE
      always_comb begin
        state_next = state_reg;
        case (state_reg)
          ST_IDLE:   if (grant[gi]) state_next = ST_QUEUED;
          ST_QUEUED: if (ar_fire && (ar_owner_reg == OWNER)) state_next = ST_WAIT_R;
          ST_WAIT_R: if (r_match[gi]) state_next = ST_IDLE;
          default:   state_next = ST_IDLE;
        endcase
      end

      // Returned word capture and one-cycle delivery pulse
      always_ff @(posedge clock) begin
        if (reset) begin
          data_ready_reg <= 1'b0;
          read_data_reg  <= 32'd0;
        end else begin
          data_ready_reg <= r_match[gi];
          if (r_match[gi]) begin
            read_data_reg <= axi_read_data;
          end
        end
      end

      assign data_ready_vec[gi] = data_ready_reg;
      assign read_data_vec[gi]  = read_data_reg;
    end
  endgenerate

  // Arbitration: a lone eligible requester wins; on a tie the one not granted last wins
  always_comb begin
    grant = '0;
    if (!reset && ar_free) begin
      if (&eligible) begin
        if (last_grant_reg == 1'b0) begin
          grant[REQ_DATA] = 1'b1;
        end else begin
          grant[REQ_INST] = 1'b1;
        end
      end else begin
        grant = eligible;
      end
    end
  end

  // AR register next value: a new grant overrides the entry leaving this cycle
  always_comb begin
    ar_full_next    = ar_full_reg;
    ar_owner_next   = ar_owner_reg;
    ar_id_next      = ar_id_reg;
    ar_addr_next    = ar_addr_reg;
    ar_size_next    = ar_size_reg;
    last_grant_next = last_grant_reg;
    if (ar_fire) begin
      ar_full_next = 1'b0;
    end
    if (|grant) begin
      ar_full_next    = 1'b1;
      ar_owner_next   = grant[REQ_DATA];
      ar_id_next      = grant[REQ_DATA] ? DATA_ID      : INST_ID;
      ar_addr_next    = grant[REQ_DATA] ? data_address : inst_address;
      ar_size_next    = grant[REQ_DATA] ? data_size    : inst_size;
      last_grant_next = grant[REQ_DATA];
    end
  end

  // AR register and arbitration history
  always_ff @(posedge clock) begin
    if (reset) begin
      ar_full_reg    <= 1'b0;
      ar_owner_reg   <= 1'b0;
      ar_id_reg      <= 4'd0;
      ar_addr_reg    <= 32'd0;
      ar_size_reg    <= 2'd0;
      last_grant_reg <= 1'b0;
    end else begin
      ar_full_reg    <= ar_full_next;
      ar_owner_reg   <= ar_owner_next;
      ar_id_reg      <= ar_id_next;
      ar_addr_reg    <= ar_addr_next;
      ar_size_reg    <= ar_size_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // R channel is always accepted once out of reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ready_reg <= 1'b0;
    end else begin
      r_ready_reg <= 1'b1;
    end
  end

  // Sticky flag for stray IDs, error responses and beats without last
  always_ff @(posedge clock) begin
    if (reset) begin
      protocol_error_reg <= 1'b0;
    end else if (r_fire && ((r_match == '0) ||
                            (axi_read_data_response != 2'b00) ||
                            !axi_read_data_last)) begin
      protocol_error_reg <= 1'b1;
    end
  end

  // Output decode
  always_comb begin
    inst_address_ready = grant[REQ_INST];
    data_address_ready = grant[REQ_DATA];
    inst_data_ready    = data_ready_vec[REQ_INST];
    data_data_ready    = data_ready_vec[REQ_DATA];
    inst_read_data     = read_data_vec[REQ_INST];
    data_read_data     = read_data_vec[REQ_DATA];
  end

  assign axi_read_address_id         = ar_id_reg;
  assign axi_read_address            = ar_addr_reg;
  assign axi_read_address_length     = 8'd0;
  assign axi_read_address_size       = {1'b0, ar_size_reg};
  assign axi_read_address_burst      = 2'b01;
  assign axi_read_address_lock       = 2'd0;
  assign axi_read_address_cache      = 4'd0;
  assign axi_read_address_protection = 3'd0;
  assign axi_read_address_valid      = ar_full_reg;
  assign axi_read_data_ready         = r_ready_reg;
  assign protocol_error              = protocol_error_reg;

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Shares one AXI4 read channel pair (AR/R) between the instruction-fetch and data-load SRAM-like requesters of the CPU. It grants one request at a time into a single-entry AR holding register, tags it with a per-requester ID, and steers returning R beats back by ID. Each requester may have at most one read outstanding, so the two reads can overlap on the bus. The block sits between the pipeline's SRAM-like read ports and the AXI system bus; writes bypass it.

## Interface
Parameters:
- INST_ID, 4'd0, AXI ID tagging instruction reads
- DATA_ID, 4'd1, AXI ID tagging data reads (must differ from INST_ID)

Ports:
- clock  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-high
- inst_request / data_request  in  1  requester wants a read
- inst_size / data_size  in  2  log2 bytes (0,1,2)
- inst_address / data_address  in  32  byte address
- inst_address_ready / data_address_ready  out  1  request accepted this cycle (combinational)
- inst_read_data / data_read_data  out  32  returned word (registered)
- inst_data_ready / data_data_ready  out  1  one-cycle pulse, read_data valid
- axi_read_address_id  out  4
- axi_read_address  out  32
- axi_read_address_length  out  8  constant 0
- axi_read_address_size  out  3  {1'b0, latched size}
- axi_read_address_burst  out  2  constant 2'b01
- axi_read_address_lock / _cache / _protection  out  2/4/3  constant 0
- axi_read_address_valid  out  1
- axi_read_address_ready  in  1
- axi_read_data_id  in  4
- axi_read_data  in  32
- axi_read_data_response  in  2
- axi_read_data_last  in  1
- axi_read_data_valid  in  1
- axi_read_data_ready  out  1  constant 1 after reset
- protocol_error  out  1  sticky error flag

## Operation
- Per-requester state: IDLE -> QUEUED (held in AR register) -> WAIT_R -> IDLE.
- AR register "free" = empty, or ARVALID&&ARREADY this cycle.
- Requester eligible: request=1, state IDLE. Grant only when AR register free.
- Arbitration: one eligible -> it wins. Both -> the one not granted last; last_grant resets to instruction (data wins first tie).
- On grant: address_ready=1 that cycle; address, size, ID latched; state QUEUED; last_grant updated.
- ARVALID=1 while register full; payload stable until ARREADY. On handshake: owner -> WAIT_R.
- R handshake (valid && ready): ID matches requester in WAIT_R -> latch data into its read_data, pulse its data_ready next cycle, state -> IDLE. last ignored (length 0).
- protocol_error set (sticky until reset) on: R beat with ID matching no WAIT_R requester; response != 2'b00 (data still delivered); last=0 on a beat.
- read_data holds last delivered value between pulses.

## Timing
- Reset values: all address_ready/data_ready 0, read_data 0, ARVALID 0, AR payload 0, protocol_error 0, states IDLE, axi_read_data_ready 0 during reset cycle, 1 afterwards.
- Request at cycle t with register free: address_ready at t, ARVALID at t+1.
- Back-to-back: AR handshake at t+1 and other requester eligible -> its grant at t+1, ARVALID stays 1 at t+2 with new ID.
- R beat at cycle r -> data_ready pulse and read_data at r+1.
- A requester is eligible again from cycle r+1; same-cycle R and new request from that requester: request not granted at r.
- Both R beats arrive in separate cycles; R beats in any order are accepted.
- Reset mid-operation: all state cleared on next edge, ARVALID drops, outstanding reads abandoned; the AXI slave is reset together with this block.

## Test plan
- Single inst read addr 0x1FC00000 size 2, ARREADY at once, R id 0 data 0xDEADBEEF 3 cycles later -> inst_address_ready at t, ARVALID t+1 with id 0, size 3'b010, length 0; inst_data_ready pulse with 0xDEADBEEF one cycle after R.
- Simultaneous inst/data requests after reset -> data granted first (id 1), inst granted the cycle of the data AR handshake, ARVALID continuous 2 cycles.
- ARREADY held low 5 cycles -> ARVALID and payload stable; no further grants; both address_ready 0.
- Overlapped reads, R returns data id 1 then inst id 0 -> each routed to correct port, no cross pulse, protocol_error 0.
- R beat id 1 with no data read outstanding, then R with response 2'b10 -> protocol_error rises and stays 1; no spurious data_ready for the stray beat.
- Reset asserted while WAIT_R -> next cycle all outputs at reset values; new request after reset served normally.
